// File: rtl/mux_seq_pkg.sv
// Shared types and truth-table constants for the bit-serial mux gate sequencer.
package mux_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        SEL  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Truth tables are indexed as tt[{b, a}].
    localparam logic [3:0] TT_AND    = 4'b1000;
    localparam logic [3:0] TT_OR     = 4'b1110;
    localparam logic [3:0] TT_XOR    = 4'b0110;
    localparam logic [3:0] TT_NAND   = 4'b0111;
    localparam logic [3:0] TT_NOR    = 4'b0001;
    localparam logic [3:0] TT_XNOR   = 4'b1001;
    localparam logic [3:0] TT_PASS_A = 4'b1010;
    localparam logic [3:0] TT_PASS_B = 4'b1100;

endpackage

// File: rtl/mux_gate_sequencer_mux.sv
// The single shared 2:1 mux that evaluates every pass of every result bit.
module mux_gate_sequencer_mux (
    input  logic d0_i,
    input  logic d1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Bit-serial 2-input logic unit: three mux passes (LO, HI, SEL) per result bit, LSB first.
// One request in flight; the result is held in DONE until the consumer takes it.
module mux_gate_sequencer
    import mux_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [3:0]       tt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] res,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       tt_q, tt_d;
    logic             t0_q, t0_d;
    logic             t1_q, t1_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic mux_d0, mux_d1, mux_sel, mux_y;

    mux_gate_sequencer_mux u_mux (
        .d0_i  (mux_d0),
        .d1_i  (mux_d1),
        .sel_i (mux_sel),
        .y_o   (mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tt_q    <= '0;
            t0_q    <= 1'b0;
            t1_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tt_q    <= tt_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        tt_d    = tt_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        res_d   = res_q;
        mux_d0  = 1'b0;
        mux_d1  = 1'b0;
        mux_sel = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    a_d     = a;
                    b_d     = b;
                    tt_d    = tt;
                    idx_d   = '0;
                    state_d = LO;
                end
            end
            LO: begin
                mux_d0  = tt_q[0];
                mux_d1  = tt_q[1];
                mux_sel = a_q[idx_q];
                t0_d    = mux_y;
                state_d = HI;
            end
            HI: begin
                mux_d0  = tt_q[2];
                mux_d1  = tt_q[3];
                mux_sel = a_q[idx_q];
                t1_d    = mux_y;
                state_d = SEL;
            end
            SEL: begin
                mux_d0       = t0_q;
                mux_d1       = t1_q;
                mux_sel      = b_q[idx_q];
                res_d[idx_q] = mux_y;
                // idx saturates at the last bit; the next accept clears it.
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LO;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_rdy = (state_q == IDLE);
    assign res_vld = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign res     = res_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Self-checking bench for mux_gate_sequencer: directed vector table, corner sequences,
// and randomized back-to-back traffic against a truth-table reference model.
module tb_mux_gate_sequencer;
    import mux_seq_pkg::*;

    localparam int W = 8;
    localparam int LAT = 3 * W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_vld = 1'b0;
    logic         res_rdy = 1'b1;
    logic [3:0]   tt = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         req_rdy;
    logic         res_vld;
    logic         busy;
    logic [W-1:0] res;

    int errors = 0;
    int checks = 0;

    mux_gate_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .tt      (tt),
        .a       (a),
        .b       (b),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_op(input logic [3:0] t, input logic [W-1:0] av,
                                            input logic [W-1:0] bv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i] = t[{bv[i], av[i]}];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request and returns the number of edges from accept until res_vld
    // is seen. abort_at stops early at that count; mid_at disturbs inputs while busy.
    task automatic issue(input logic [3:0] t, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int abort_at, input int mid_at, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy_before_issue", 32'(req_rdy), 32'd1);
        tt = t;
        a = av;
        b = bv;
        req_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
        lat = 0;
        while (!res_vld && lat < 100) begin
            if (lat == abort_at) return;
            if (mid_at >= 0 && lat == mid_at) begin
                check("req_rdy_while_busy", 32'(req_rdy), 32'd0);
                a = '0;
                b = ~bv;
                tt = ~t;
                req_vld = 1'b1;
            end else if (mid_at >= 0 && lat == mid_at + 1) begin
                req_vld = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0]   tt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[10];
        int lat;
        logic [W-1:0] expq[$];
        logic [W-1:0] e;
        int cyc, last_acc, got;
        logic prev_vld, pend;

        vecs[0] = '{TT_XOR,    8'hA5, 8'h3C, 8'h99};
        vecs[1] = '{TT_AND,    8'hF0, 8'h3C, 8'h30};
        vecs[2] = '{TT_NOR,    8'hF0, 8'h3C, 8'h03};
        vecs[3] = '{TT_PASS_B, 8'hF0, 8'h3C, 8'h3C};
        vecs[4] = '{4'b1111,   8'hF0, 8'h3C, 8'hFF};
        vecs[5] = '{TT_OR,     8'hF0, 8'h3C, 8'hFC};
        vecs[6] = '{TT_NAND,   8'hF0, 8'h3C, 8'hCF};
        vecs[7] = '{TT_XNOR,   8'hA5, 8'h3C, 8'h66};
        vecs[8] = '{TT_PASS_A, 8'hA5, 8'h3C, 8'hA5};
        vecs[9] = '{4'b0000,   8'hFF, 8'hFF, 8'h00};

        // Reset state
        @(negedge clk);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_res_vld", 32'(res_vld), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_res",     32'(res),     32'd0);
        rst = 1'b0;

        // Directed vectors with an always-ready consumer
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].tt, vecs[i].a, vecs[i].b, -1, -1, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].exp));
            @(negedge clk);
            check($sformatf("vec%0d_vld_one_cycle", i), 32'(res_vld), 32'd0);
            check($sformatf("vec%0d_req_rdy_after", i), 32'(req_rdy), 32'd1);
        end

        // Backpressure: result held while the consumer stalls
        res_rdy = 1'b0;
        issue(TT_XOR, 8'hA5, 8'h3C, -1, -1, lat);
        check("bp_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_vld", 32'(res_vld), 32'd1);
            check("bp_res",     32'(res),     32'h99);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
        end
        res_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_req_rdy", 32'(req_rdy), 32'd1);
        check("bp_release_res_vld", 32'(res_vld), 32'd0);
        check("bp_res_kept",        32'(res),     32'h99);

        // Inputs change and req_vld pulses while busy
        issue(TT_XOR, 8'hA5, 8'h3C, -1, 4, lat);
        check("mid_latency", 32'(lat), 32'(LAT));
        check("mid_res", 32'(res), 32'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_accept_busy", 32'(busy), 32'd0);
        end

        // Asynchronous reset mid-operation
        issue(TT_XOR, 8'hA5, 8'h3C, 10, -1, lat);
        check("arst_busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_req_rdy", 32'(req_rdy), 32'd1);
        check("arst_res_vld", 32'(res_vld), 32'd0);
        check("arst_res",     32'(res),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(TT_OR, 8'h01, 8'h80, -1, -1, lat);
        check("arst_next_latency", 32'(lat), 32'(LAT));
        check("arst_next_res", 32'(res), 32'h81);

        // Back-to-back random traffic. Per transaction: one IDLE cycle (accept),
        // LAT busy cycles, one DONE cycle, so accepts are LAT+2 edges apart.
        @(negedge clk);
        res_rdy = 1'b1;
        tt = 4'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        req_vld = 1'b1;
        cyc = 0;
        last_acc = -1;
        got = 0;
        prev_vld = 1'b0;
        while (got < 20 && cyc < 2000) begin
            pend = 1'b0;
            if (prev_vld) check("b2b_vld_one_cycle", 32'(res_vld), 32'd0);
            if (res_vld) begin
                if (expq.size() == 0) begin
                    check("b2b_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("b2b_res%0d", got), 32'(res), 32'(e));
                end
                got++;
            end
            if (req_rdy) begin
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(LAT + 2));
                last_acc = cyc;
                expq.push_back(ref_op(tt, a, b));
                pend = 1'b1;
            end
            prev_vld = res_vld;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (pend) begin
                tt = 4'($urandom);
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        req_vld = 1'b0;
        check("b2b_result_count", 32'(got), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
